// File: rtl/conv_layer_stream_ctrl_pkg.sv
// conv_ctrl_pkg: shared definitions for the 3x3 convolution stream controller.
//   state_t     - pass sequencing states (IDLE, STREAM, DRAIN, DONE)
//   clog2_safe  - ceil(log2(value)), never less than 1, usable for port widths
//   CH_WIDTH    - width of one packed channel inside a pixel word
package conv_ctrl_pkg;

  localparam int CH_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bounded loop so it elaborates as a constant function; a result of 0 would
  // produce a zero-width vector, hence the floor of 1.
  function automatic int clog2_safe(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_layer_stream_ctrl_pos_counter.sv
// pos_counter: 2D raster position counter (column fastest) over a LIMIT x LIMIT
// grid.
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous clear to (0,0); has priority over en
//   en         - advance one position
//   row, col   - current position
//   frame_end  - en while sitting on the last position (LIMIT-1, LIMIT-1)
module pos_counter
  import conv_ctrl_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = clog2_safe(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         frame_end
);

  logic col_last;
  logic row_last;

  assign col_last  = (col == W'(LIMIT - 1));
  assign row_last  = (row == W'(LIMIT - 1));
  assign frame_end = en && col_last && row_last;

  // Position register: column wraps into a row increment, row wraps at the frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_stream_ctrl.sv
// conv_layer_stream_ctrl: sequences one feature-map pass of a 3x3 conv layer.
// Ports:
//   Clk, Rst        - clock, asynchronous active-high reset
//   start, abort    - begin a pass (IDLE only) / return to IDLE from anywhere
//   src_*           - pixel stream from the input buffer (valid/ready)
//   sink_ready      - output store can absorb a full conv pipeline of results
//   conv_data/valid - registered pixel forward to the featuremap instances
//   conv_valid_out  - result strobe coming back from the featuremap instances
//   out_row/out_col - coordinates of the result strobed this cycle
//   out_tag_valid   - coordinates valid (result strobe while busy)
//   busy, done, err - in STREAM/DRAIN, end-of-pass pulse, sticky protocol error
module conv_layer_stream_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_SIZE      = 416,
  parameter int DATA_IN_WIDTH = 96
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [DATA_IN_WIDTH-1:0]       src_data,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic                           sink_ready,
  output logic [DATA_IN_WIDTH-1:0]       conv_data,
  output logic                           conv_valid,
  input  logic                           conv_valid_out,
  output logic [clog2_safe(IMG_SIZE)-1:0] out_row,
  output logic [clog2_safe(IMG_SIZE)-1:0] out_col,
  output logic                           out_tag_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int OUT_SIZE = IMG_SIZE - 2;
  localparam int PW       = clog2_safe(IMG_SIZE);
  localparam int CNT_W    = clog2_safe(OUT_SIZE * OUT_SIZE + 1);
  localparam logic [CNT_W-1:0] OUT_TOTAL = CNT_W'(OUT_SIZE * OUT_SIZE);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             cnt_clr;
  logic             last_pixel;
  logic             out_strobe;
  logic             out_full;
  logic             out_adv;
  logic             out_frame_end;
  logic             overrun;
  logic [CNT_W-1:0] out_cnt;
  logic [PW-1:0]    in_row;
  logic [PW-1:0]    in_col;

  assign src_ready     = (state == ST_STREAM) && sink_ready;
  assign accept        = src_valid && src_ready;
  assign out_strobe    = conv_valid_out && busy;
  assign out_tag_valid = out_strobe;
  assign out_full      = (out_cnt == OUT_TOTAL);
  assign overrun       = out_strobe && out_full;
  // Positions stop advancing once the frame is complete so the tag of an
  // overrunning strobe does not wrap back into the frame.
  assign out_adv       = out_strobe && !out_full;
  // Counters restart on abort and on the IDLE->STREAM entry (abort wins anyway).
  assign cnt_clr       = abort || ((state == ST_IDLE) && start);

  pos_counter #(.LIMIT(IMG_SIZE), .W(PW)) u_in_pos (
    .clk       (Clk),
    .rst       (Rst),
    .clr       (cnt_clr),
    .en        (accept),
    .row       (in_row),
    .col       (in_col),
    .frame_end (last_pixel)
  );

  // out_frame_end fires on the strobe that writes the final result, i.e. the
  // one that moves out_cnt to OUT_TOTAL.
  pos_counter #(.LIMIT(OUT_SIZE), .W(PW)) u_out_pos (
    .clk       (Clk),
    .rst       (Rst),
    .clr       (cnt_clr),
    .en        (out_adv),
    .row       (out_row),
    .col       (out_col),
    .frame_end (out_frame_end)
  );

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_next = ST_STREAM;
          else       state_next = ST_IDLE;
        end
        ST_STREAM: begin
          if (last_pixel) state_next = ST_DRAIN;
          else            state_next = ST_STREAM;
        end
        ST_DRAIN: begin
          // Either the count was already reached during STREAM, or the last
          // result is being strobed right now.
          if (out_full || out_frame_end) state_next = ST_DONE;
          else                           state_next = ST_DRAIN;
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_STREAM) || (state_next == ST_DRAIN);
      done  <= (state_next == ST_DONE);
    end
  end

  // Pixel forwarding register: one cycle behind the accept, data held otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      conv_valid <= 1'b0;
      conv_data  <= '0;
    end else begin
      conv_valid <= accept && !abort;
      if (accept && !abort) begin
        conv_data <= src_data;
      end
    end
  end

  // Result counter; saturates at OUT_TOTAL, further strobes are flagged as overrun.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_cnt <= '0;
    end else if (cnt_clr) begin
      out_cnt <= '0;
    end else if (out_adv) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Sticky error: stray result strobe outside a pass, or more results than positions.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err <= 1'b0;
    end else begin
      err <= err || (conv_valid_out && !busy) || overrun;
    end
  end

endmodule

// File: tb/tb_conv_layer_stream_ctrl.sv
// Directed bench for conv_layer_stream_ctrl with a 4x4 image (2x2 outputs).
module tb_conv_layer_stream_ctrl;

  localparam int IMG = 4;
  localparam int DW  = 96;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          sink_ready;
  logic [DW-1:0] conv_data;
  logic          conv_valid;
  logic          conv_valid_out;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          out_tag_valid;
  logic          busy;
  logic          done;
  logic          err;

  int vec;
  int miss;

  conv_layer_stream_ctrl #(.IMG_SIZE(IMG), .DATA_IN_WIDTH(DW)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .start          (start),
    .abort          (abort),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .sink_ready     (sink_ready),
    .conv_data      (conv_data),
    .conv_valid     (conv_valid),
    .conv_valid_out (conv_valid_out),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_tag_valid  (out_tag_valid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] pix(input int i);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = i + 7;
    b = 3 * i + 1;
    c = i + 100;
    return {a, b, c};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL start_busy: got %b want 1", busy); end
  endtask

  // Streams pixels until src_ready drops; optional 3-cycle sink stall after
  // stall_at accepts, optional result strobes on the last four pixels.
  task automatic stream_full(input int stall_at, input bit strobe_tail, output int n);
    int stalls;
    n = 0;
    stalls = 0;
    src_valid = 1'b1;
    for (int c = 0; c < 48; c++) begin
      if (n == stall_at && stalls < 3) begin
        sink_ready = 1'b0;
        conv_valid_out = 1'b0;
        #1;
        vec++; if (src_ready !== 1'b0) begin miss++; $display("FAIL stall_ready: got %b want 0", src_ready); end
        tick();
        vec++; if (conv_valid !== 1'b0) begin miss++; $display("FAIL stall_conv_valid: got %b want 0", conv_valid); end
        stalls++;
      end else begin
        sink_ready = 1'b1;
        #1;
        if (!src_ready) break;
        src_data = pix(n);
        conv_valid_out = strobe_tail && (n >= 12);
        #1;
        if (conv_valid_out) begin
          vec++;
          if (out_tag_valid !== 1'b1 || out_row !== 2'((n - 12) / 2) || out_col !== 2'((n - 12) % 2)) begin
            miss++;
            $display("FAIL stream_tag: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                     out_tag_valid, out_row, out_col, (n - 12) / 2, (n - 12) % 2);
          end
        end
        tick();
        n++;
        vec++;
        if (conv_valid !== 1'b1 || conv_data !== pix(n - 1)) begin
          miss++;
          $display("FAIL forward_%0d: got v=%b d=%h want v=1 d=%h", n - 1, conv_valid, conv_data, pix(n - 1));
        end
      end
    end
    conv_valid_out = 1'b0;
  endtask

  // Four result strobes in DRAIN: checks tags, then the single done pulse.
  task automatic drain_pass();
    for (int k = 0; k < 4; k++) begin
      conv_valid_out = 1'b1;
      #1;
      vec++;
      if (out_tag_valid !== 1'b1 || out_row !== 2'(k / 2) || out_col !== 2'(k % 2)) begin
        miss++;
        $display("FAIL drain_tag_%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                 k, out_tag_valid, out_row, out_col, k / 2, k % 2);
      end
      tick();
      if (k < 3) begin
        vec++; if (done !== 1'b0 || busy !== 1'b1) begin miss++; $display("FAIL drain_early_%0d: got done=%b busy=%b want 0/1", k, done, busy); end
      end
    end
    conv_valid_out = 1'b0;
    vec++; if (done !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL done_pulse: got done=%b busy=%b want 1/0", done, busy); end
    tick();
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_reset();
    #12;
    vec++;
    if (conv_data !== '0 || conv_valid !== 1'b0 || src_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || out_tag_valid !== 1'b0 || out_row !== 2'd0 || out_col !== 2'd0) begin
      miss++;
      $display("FAIL reset_state: got d=%h v=%b rdy=%b busy=%b done=%b err=%b tag=%b (%0d,%0d) want all zero",
               conv_data, conv_valid, src_ready, busy, done, err, out_tag_valid, out_row, out_col);
    end
    Rst = 1'b0;
  endtask

  task automatic test_stream();
    int n;
    start_pass();
    vec++; if (src_ready !== 1'b1) begin miss++; $display("FAIL stream_ready: got %b want 1", src_ready); end
    stream_full(-1, 1'b0, n);
    vec++; if (n !== 16) begin miss++; $display("FAIL stream_accepts: got %0d want 16", n); end
    tick();
    vec++;
    if (src_ready !== 1'b0 || busy !== 1'b1 || conv_valid !== 1'b0 || done !== 1'b0) begin
      miss++;
      $display("FAIL drain_hold: got rdy=%b busy=%b v=%b done=%b want 0/1/0/0", src_ready, busy, conv_valid, done);
    end
    src_valid = 1'b0;
  endtask

  task automatic test_drain();
    drain_pass();
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL drain_err: got %b want 0", err); end
  endtask

  task automatic test_stall();
    int n;
    start_pass();
    stream_full(5, 1'b1, n);
    src_valid = 1'b0;
    vec++; if (n !== 16) begin miss++; $display("FAIL stall_accepts: got %0d want 16", n); end
    vec++; if (busy !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL stall_drain: got busy=%b done=%b want 1/0", busy, done); end
    tick();
    vec++; if (done !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL stall_done: got done=%b busy=%b want 1/0", done, busy); end
    tick();
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL stall_done_width: got %b want 0", done); end
  endtask

  task automatic test_abort();
    int n;
    start_pass();
    src_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      src_data = pix(i);
      conv_valid_out = (i == 3);
      tick();
    end
    conv_valid_out = 1'b0;
    src_data = pix(9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    src_valid = 1'b0;
    vec++;
    if (busy !== 1'b0 || conv_valid !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0) begin
      miss++;
      $display("FAIL abort_idle: got busy=%b v=%b done=%b rdy=%b want 0/0/0/0", busy, conv_valid, done, src_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (done !== 1'b0 || busy !== 1'b0) begin miss++; $display("FAIL abort_quiet: got done=%b busy=%b want 0/0", done, busy); end
    end
    start_pass();
    stream_full(-1, 1'b0, n);
    src_valid = 1'b0;
    vec++; if (n !== 16) begin miss++; $display("FAIL restart_accepts: got %0d want 16", n); end
    drain_pass();
  endtask

  task automatic test_start_abort();
    int n;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vec++; if (busy !== 1'b0 || src_ready !== 1'b0) begin miss++; $display("FAIL start_abort: got busy=%b rdy=%b want 0/0", busy, src_ready); end
    tick();
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL start_abort_queued: got %b want 0", busy); end
    start_pass();
    stream_full(-1, 1'b0, n);
    src_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++; if (busy !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL start_in_drain: got busy=%b done=%b want 1/0", busy, done); end
    drain_pass();
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (done !== 1'b0 || busy !== 1'b0) begin miss++; $display("FAIL extra_pass_%0d: got done=%b busy=%b want 0/0", i, done, busy); end
    end
  endtask

  task automatic test_err();
    int n;
    conv_valid_out = 1'b1;
    #1;
    vec++; if (out_tag_valid !== 1'b0) begin miss++; $display("FAIL idle_tag: got %b want 0", out_tag_valid); end
    tick();
    conv_valid_out = 1'b0;
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL idle_strobe_err: got %b want 1", err); end
    start_pass();
    stream_full(-1, 1'b0, n);
    src_valid = 1'b0;
    drain_pass();
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL err_sticky: got %b want 1", err); end
    @(negedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    vec++;
    if (err !== 1'b0 || conv_data !== '0 || conv_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0) begin
      miss++;
      $display("FAIL async_reset: got err=%b d=%h v=%b busy=%b done=%b rdy=%b want all zero",
               err, conv_data, conv_valid, busy, done, src_ready);
    end
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_overrun();
    int n;
    start_pass();
    stream_full(-1, 1'b1, n);
    src_valid = 1'b0;
    vec++; if (n !== 16 || err !== 1'b0) begin miss++; $display("FAIL overrun_setup: got n=%0d err=%b want 16/0", n, err); end
    conv_valid_out = 1'b1;
    #1;
    vec++; if (out_tag_valid !== 1'b1) begin miss++; $display("FAIL overrun_tag: got %b want 1", out_tag_valid); end
    tick();
    conv_valid_out = 1'b0;
    vec++; if (err !== 1'b1 || done !== 1'b1) begin miss++; $display("FAIL overrun_err: got err=%b done=%b want 1/1", err, done); end
    tick();
  endtask

  initial begin
    vec = 0;
    miss = 0;
    Rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src_data = '0;
    src_valid = 1'b0;
    sink_ready = 1'b1;
    conv_valid_out = 1'b0;
    test_reset();
    test_stream();
    test_drain();
    test_stall();
    test_abort();
    test_start_abort();
    test_err();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_layer_stream_ctrl.md
Name: conv_layer_stream_ctrl

Overview:
- Sequences one feature-map pass of a 3x3 convolution layer.
- Accepts a raster-order pixel stream (three 32-bit channels packed per word) from the input buffer over a valid/ready handshake.
- Forwards each accepted pixel to the per-channel Conv2D3x3 instances, counts input and output positions, tags each output with its coordinates, and signals completion.
- Sits between the frame buffer reader and the layer_N_featuremap_* instances.

Parameters:
- IMG_SIZE, 416, input image width and height in pixels (square image); legal range 3..4096.
- DATA_IN_WIDTH, 96, packed pixel width (3 channels x 32-bit float).
- OUT_SIZE, IMG_SIZE-2, valid-convolution output width and height; derived, do not override.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a pass; ignored unless the FSM is in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- src_data  in  DATA_IN_WIDTH  pixel from the input buffer
- src_valid  in  1  src_data valid
- src_ready  out  1  controller accepts src_data this cycle
- sink_ready  in  1  downstream output store has room for at least one conv pipeline depth of results
- conv_data  out  DATA_IN_WIDTH  pixel to the featuremap instances
- conv_valid  out  1  conv_data valid
- conv_valid_out  in  1  result strobe from the featuremap instances
- out_row  out  $clog2(IMG_SIZE)  row of the current result
- out_col  out  $clog2(IMG_SIZE)  column of the current result
- out_tag_valid  out  1  out_row/out_col valid; equals conv_valid_out gated by busy
- busy  out  1  high in STREAM or DRAIN
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  sticky: result strobe seen while in IDLE/DONE, or output overrun

Behaviour:
- Reset (Rst=1, asynchronous):
  - state=IDLE.
  - All counters cleared.
  - conv_data=0; conv_valid, src_ready, busy, done and err all 0.
- States: IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM on start.
  - STREAM -> DRAIN on the accepted handshake of pixel (IMG_SIZE-1, IMG_SIZE-1).
  - DRAIN -> DONE when the output count reaches OUT_SIZE*OUT_SIZE.
  - DONE -> IDLE after exactly 1 cycle; done=1 only in DONE.
- Input handshake:
  - src_ready = (state==STREAM) && sink_ready. This is combinational from registered state plus the sink_ready input.
  - An accept occurs when src_valid && src_ready.
- Forwarding:
  - conv_data and conv_valid are registered: 1-cycle latency from accept.
  - conv_valid=0 on cycles with no accept; conv_data holds its last value.
- Input counters (in_col, in_row):
  - in_col increments on each accept and wraps at IMG_SIZE-1 to 0.
  - in_row increments on in_col wrap.
  - Both are cleared on entry to STREAM.
- Output counters (out_col, out_row, out_cnt):
  - Advance on conv_valid_out while busy; out_col wraps at OUT_SIZE-1.
  - out_cnt width is $clog2(OUT_SIZE*OUT_SIZE+1).
  - Outputs arriving during STREAM are counted; if the final output arrives in STREAM, the count check happens in DRAIN on the next cycle.
- Tagging: out_row/out_col present the coordinates of the result strobed in the same cycle; the counter updates after it.
- Completion: after the accept of the last input pixel, src_ready stays low in DRAIN even if src_valid is asserted.
- Error cases (err is sticky until Rst):
  - conv_valid_out while not busy sets err.
  - conv_valid_out when out_cnt already equals OUT_SIZE^2 sets err.
- Abort:
  - On the next edge: state=IDLE, counters cleared, conv_valid=0, no done pulse. err is retained.
  - abort has priority over start and over every other transition in the same cycle.
- Simultaneous start and abort in IDLE: remain in IDLE.
- start during STREAM, DRAIN or DONE is ignored and not queued.
- Mid-operation reset: all state is lost; the pass must be restarted.

Decomposition:
- Shared package conv_ctrl_pkg:
  - FSM state enum.
  - Function clog2_safe.
  - Constant CH_WIDTH=32.
- Sub-module pos_counter (parameter LIMIT): 2D row/column wrap counter with clear and enable, instantiated twice (input and output positions).

Test Plan (all scenarios use IMG_SIZE=4, OUT_SIZE=2):
1. Reset then start with src_valid held high and sink_ready=1 -> src_ready high 16 consecutive cycles; conv_valid follows each accept by 1 cycle; state DRAIN after pixel 16.
2. Inject 4 conv_valid_out strobes during DRAIN -> out_row/out_col read (0,0),(0,1),(1,0),(1,1); done pulses exactly 1 cycle after the 4th strobe cycle; busy falls the same cycle done rises.
3. Toggle sink_ready low for 3 cycles mid-row (after pixel 5) -> no accepts and conv_valid=0 for those cycles; in_col resumes at 1, row 1; total accepts still 16.
4. Assert abort at pixel 9 -> IDLE next cycle, busy=0, no done; a new start streams from (0,0).
5. Pulse conv_valid_out in IDLE -> err=1 and stays 1 across a following full pass; assert Rst asynchronously mid-cycle -> err=0 and outputs zero before the next edge.
6. start and abort asserted together in IDLE -> stays IDLE; start asserted during DRAIN -> ignored, exactly one done pulse.
